// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions: instruction width, opcodes and fetch state encoding.
package instr_fetch_unit_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned FUNC_W   = 6;
   localparam int unsigned TARGET_W = 26;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential, branch target or jump target.
module next_pc_calc
   import instr_fetch_unit_pkg::*;
(
   input  logic [INSTR_W-1:0]  pc,
   input  logic [TARGET_W-1:0] target,
   input  logic                jump,
   input  logic                branch,
   input  logic                zero,
   output logic [INSTR_W-1:0]  pcplus4_c,
   output logic [INSTR_W-1:0]  next_pc_c
);

   logic [INSTR_W-1:0] branch_off;
   logic [INSTR_W-1:0] branch_tgt;
   logic [INSTR_W-1:0] jump_tgt;

   assign pcplus4_c  = pc + INSTR_W'(4);
   // Sign-extended word offset, already scaled to bytes
   assign branch_off = {{14{target[15]}}, target[15:0], 2'b00};
   assign branch_tgt = pcplus4_c + branch_off;
   assign jump_tgt   = {pcplus4_c[31:28], target, 2'b00};

   // Jump wins over a taken branch
   always_comb begin
      next_pc_c = pcplus4_c;
      if (jump)
         next_pc_c = jump_tgt;
      else if (branch && zero)
         next_pc_c = branch_tgt;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, fetch handshake FSM, held instruction, retire counter.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned        CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [INSTR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_ready,
   input  logic                advance,
   input  logic                branch,
   input  logic                zero,
   input  logic                jump,
   output logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   output logic [FUNC_W-1:0]   func,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  pc,
   output logic [INSTR_W-1:0]  pcplus4,
   output logic [CNT_W-1:0]    retired
);

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   logic [INSTR_W-1:0] pc_nxt;
   logic [INSTR_W-1:0] instr_nxt;
   logic [CNT_W-1:0]   retired_nxt;
   logic               imem_req_nxt;
   logic               instr_valid_nxt;
   logic [INSTR_W-1:0] next_pc;

   next_pc_calc u_next_pc (
      .pc        (pc),
      .target    (instr[TARGET_W-1:0]),
      .jump      (jump),
      .branch    (branch),
      .zero      (zero),
      .pcplus4_c (pcplus4),
      .next_pc_c (next_pc)
   );

   assign imem_addr = pc;
   assign opcode    = instr[31:26];
   assign func      = instr[5:0];

   // Next-state, datapath updates and next output flags
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      instr_nxt   = instr;
      retired_nxt = retired;
      case (state)
         BOOT: state_nxt = FETCH;
         FETCH: begin
            if (imem_ready) begin
               instr_nxt = imem_rdata;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (advance) begin
               pc_nxt      = next_pc;
               retired_nxt = retired + CNT_W'(1);
               state_nxt   = FETCH;
            end
         end
         default: state_nxt = BOOT;
      endcase
      imem_req_nxt    = (state_nxt == FETCH);
      instr_valid_nxt = (state_nxt == HOLD);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         instr       <= '0;
         retired     <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr       <= instr_nxt;
         retired     <= retired_nxt;
         imem_req    <= imem_req_nxt;
         instr_valid <= instr_valid_nxt;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

   logic        clk;
   int          checks;
   int          errors;

   // Main instance: reset PC 0, 4-bit retire counter
   logic        rst_n, imem_req, imem_ready, advance, branch, zero, jump, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4;
   logic [5:0]  opcode, func;
   logic [3:0]  retired;

   // Second instance: high reset PC for jump region checks
   logic        rst_n_h, imem_req_h, imem_ready_h, advance_h, branch_h, zero_h, jump_h, instr_valid_h;
   logic [31:0] imem_addr_h, imem_rdata_h, instr_h, pc_h, pcplus4_h, retired_h;
   logic [5:0]  opcode_h, func_h;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .advance(advance),
      .branch(branch), .zero(zero), .jump(jump), .instr(instr), .opcode(opcode),
      .func(func), .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4),
      .retired(retired)
   );

   instr_fetch_unit #(.RESET_PC(32'h1000_0010), .CNT_W(32)) dut_h (
      .clk(clk), .rst_n(rst_n_h), .imem_req(imem_req_h), .imem_addr(imem_addr_h),
      .imem_rdata(imem_rdata_h), .imem_ready(imem_ready_h), .advance(advance_h),
      .branch(branch_h), .zero(zero_h), .jump(jump_h), .instr(instr_h), .opcode(opcode_h),
      .func(func_h), .instr_valid(instr_valid_h), .pc(pc_h), .pcplus4(pcplus4_h),
      .retired(retired_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h8C08_0004;
      advance = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
      rst_n_h = 1'b0; imem_ready_h = 1'b0; imem_rdata_h = 32'h0;
      advance_h = 1'b0; branch_h = 1'b0; zero_h = 1'b0; jump_h = 1'b0;

      // Reset held two cycles
      tick(); tick();
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_pc", pc, 0);
      chk("rst_instr", instr, 0);
      chk("rst_retired", retired, 0);
      chk("rst_pcplus4", pcplus4, 4);

      // BOOT idle cycle, then FETCH
      rst_n = 1'b1;
      tick();
      chk("boot_req", imem_req, 1);
      chk("boot_addr", imem_addr, 0);
      chk("boot_valid", instr_valid, 0);

      // Zero-wait fetch of lw
      tick();
      chk("lw_valid", instr_valid, 1);
      chk("lw_req", imem_req, 0);
      chk("lw_instr", instr, 32'h8C08_0004);
      chk("lw_opcode", opcode, 6'b100011);
      chk("lw_func", func, 6'b000100);
      chk("lw_pc", pc, 0);
      chk("lw_pcplus4", pcplus4, 4);

      // Advance sequentially, then 3 wait states with advance ignored
      advance = 1'b1; imem_ready = 1'b0;
      tick();
      chk("seq_pc", pc, 4);
      chk("seq_retired", retired, 1);
      chk("seq_addr", imem_addr, 4);
      chk("seq_req", imem_req, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_addr", imem_addr, 4);
         chk("wait_valid", instr_valid, 0);
         chk("wait_req", imem_req, 1);
         chk("wait_retired", retired, 1);
      end

      // Fetch add at pc 4, then stall 5 cycles with memory noise
      advance = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0109_5020;
      tick();
      chk("add_valid", instr_valid, 1);
      chk("add_func", func, 6'b100000);
      chk("add_opcode", opcode, 6'b000000);
      imem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_instr", instr, 32'h0109_5020);
         chk("stall_pc", pc, 4);
         chk("stall_pcplus4", pcplus4, 8);
         chk("stall_retired", retired, 1);
         chk("stall_valid", instr_valid, 1);
         chk("stall_req", imem_req, 0);
      end

      // Advance to pc 8 and fetch beq -2
      advance = 1'b1;
      tick();
      chk("to8_pc", pc, 8);
      advance = 1'b0; imem_rdata = 32'h1109_FFFE;
      tick();
      chk("beq_opcode", opcode, 6'b000100);

      // Branch taken: 8 + 4 - 8 = 4
      branch = 1'b1; zero = 1'b1; advance = 1'b1;
      tick();
      chk("br_taken_pc", pc, 4);
      chk("br_taken_retired", retired, 3);

      // Jump back to 8
      branch = 1'b0; zero = 1'b0; advance = 1'b0; imem_rdata = 32'h0800_0002;
      tick();
      chk("j_opcode", opcode, 6'b000010);
      jump = 1'b1; advance = 1'b1;
      tick();
      chk("j_pc", pc, 8);
      chk("j_retired", retired, 4);

      // Branch not taken (zero=0): 12
      jump = 1'b0; advance = 1'b0; imem_rdata = 32'h1109_FFFE;
      tick();
      branch = 1'b1; zero = 1'b0; advance = 1'b1;
      tick();
      chk("br_nt_pc", pc, 12);
      chk("br_nt_retired", retired, 5);

      // Branch -5 from 12: 16 - 20 wraps to FFFF_FFFC
      branch = 1'b0; advance = 1'b0; imem_rdata = 32'h1109_FFFB;
      tick();
      branch = 1'b1; zero = 1'b1; advance = 1'b1;
      tick();
      chk("br_neg_pc", pc, 32'hFFFF_FFFC);
      chk("br_neg_addr", imem_addr, 32'hFFFF_FFFC);

      // Sequential wrap of pcplus4 and pc
      branch = 1'b0; zero = 1'b0; advance = 1'b0; imem_rdata = 32'h0000_0000;
      tick();
      chk("wrap_pcplus4", pcplus4, 0);
      advance = 1'b1;
      tick();
      chk("wrap_pc", pc, 0);
      chk("wrap_retired", retired, 7);

      // Back-to-back: one instruction per 2 cycles, counter wraps after 16
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("tp_valid", instr_valid, 1);
         chk("tp_pc", pc, 32'(4 * i));
         tick();
         chk("tp_retired", retired, 32'((8 + i) % 16));
      end
      chk("tp_final_retired", retired, 7);
      chk("tp_final_pc", pc, 32'h40);

      // Reset mid-fetch with imem_ready high
      advance = 1'b0;
      chk("pre_rst_req", imem_req, 1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", instr_valid, 0);
      chk("mid_rst_instr", instr, 0);
      chk("mid_rst_pc", pc, 0);
      chk("mid_rst_retired", retired, 0);
      chk("mid_rst_req", imem_req, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_instr", instr, 0);

      // Jump priority over taken branch at high pc
      chk("h_rst_pc", pc_h, 32'h1000_0010);
      rst_n_h = 1'b1;
      tick();
      chk("h_addr", imem_addr_h, 32'h1000_0010);
      imem_ready_h = 1'b1; imem_rdata_h = 32'h0800_0040;
      tick();
      chk("h_instr", instr_h, 32'h0800_0040);
      jump_h = 1'b1; branch_h = 1'b1; zero_h = 1'b1; advance_h = 1'b1;
      imem_ready_h = 1'b0;
      tick();
      chk("h_jump_pc", pc_h, 32'h1000_0100);
      chk("h_jump_retired", retired_h, 1);
      chk("h_jump_req", imem_req_h, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control unit in the MIPS core: holds the PC and fetches each instruction from instruction memory over a ready handshake.
- Presents the held instruction, with opcode and func sliced for the control unit, until the datapath signals advance.
- Computes the next PC from the jump, branch and zero results: sequential, branch target or jump target.
- Counts retired instructions for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the fetch; always equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory has imem_rdata for the current request.
- advance  in  1  datapath has committed the held instruction.
- branch  in  1  branch control for the held instruction.
- zero  in  1  ALU zero flag for the held instruction.
- jump  in  1  jump control for the held instruction.
- instr  out  32  held instruction word.
- opcode  out  6  instr[31:26].
- func  out  6  instr[5:0].
- instr_valid  out  1  instr/opcode/func are valid.
- pc  out  32  address of the held instruction.
- pcplus4  out  32  pc + 4.
- retired  out  CNT_W  count of advanced instructions.

Behaviour:
- Reset is synchronous and active-low: clk is the only clock, and rst_n is sampled at the rising edge.
- Reset values: state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0.
- States: BOOT, FETCH, HOLD. All outputs decode from registers only; there are no combinational input-to-output paths except pcplus4, which depends only on pc.
- BOOT: imem_req=0. Moves unconditionally to FETCH on the next edge, giving one idle cycle after reset release.
- FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_ready=1 at the edge: instr<=imem_rdata, go to HOLD.
  - imem_ready=0: stay in FETCH with pc and address stable; there is no timeout.
- HOLD: imem_req=0, instr_valid=1. instr, pc and pcplus4 stay stable.
  - advance=1 at the edge: pc<=next_pc, retired<=retired+1, go to FETCH.
  - advance=0: stay in HOLD.
- advance is ignored outside HOLD. imem_ready is ignored outside FETCH.
- next_pc, evaluated in HOLD using the held instr:
  - jump=1: {pcplus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - else branch & zero: pcplus4 + (sign_extend(instr[15:0]) << 2), with 32-bit wrap-around.
  - else: pcplus4.
- pc[1:0] is always 00; RESET_PC must be aligned, and every next_pc form preserves alignment.
- pcplus4 wraps from 32'hFFFF_FFFC to 32'h0000_0000 without any flag.
- retired wraps modulo 2^CNT_W.
- Throughput with zero-wait memory: one instruction every 2 cycles (FETCH, HOLD).
- Reset mid-operation: reset in FETCH or HOLD abandons the instruction. The next cycle shows reset values, and any imem_ready seen during reset is discarded.
- Simultaneous events: advance together with jump, branch and zero resolves by the priority above in the same cycle.

Decomposition:
- Shared core package holds:
  - opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_ADDI 001000, OP_BEQ 000100, OP_J 000010;
  - the fetch state encoding (BOOT/FETCH/HOLD);
  - the INSTR_W=32 constant.
- One natural sub-module, next_pc_calc: purely combinational, computing pcplus4, the branch target, the jump target and the priority mux. The FSM, the registers and the counter stay in the top module.

Test Plan:
- Reset then zero-wait memory: rst_n low 2 cycles, then high, imem_ready=1 always, imem_rdata=32'h8C08_0004 (lw) → BOOT 1 cycle; imem_req=1 with imem_addr=0; next cycle instr_valid=1, opcode=100011, func=000100, pc=0, pcplus4=4.
- Sequential and wait states: hold imem_ready=0 for 3 FETCH cycles → imem_addr stays 0 and instr_valid=0 throughout. Then ready=1 and advance=1 in HOLD → pc=4, retired=1, imem_addr=4.
- Branch taken: pc=8, instr=32'h1109_FFFE (beq, imm=-2), branch=1, zero=1, advance → pc=8+4-8=4. With zero=0 instead → pc=12.
- Jump priority: pc=32'h1000_0010, instr=32'h0800_0040, jump=1 and branch=1, zero=1, advance → pc=32'h1000_0100.
- Stall and wrap: advance=0 for 5 HOLD cycles → outputs stable, retired unchanged. pc=32'hFFFF_FFFC with advance → pc=0. With CNT_W=4, 16 advances → retired=0.
- Reset mid-fetch: rst_n low in FETCH while imem_ready=1 → next cycle state=BOOT, instr_valid=0, instr=0, pc=RESET_PC, retired=0.
